// File: rtl/div_ctrl.sv
// div_ctrl: sequences RISC-V DIV/DIVU/REM/REMU onto a shared multi-cycle divider with special-case and last-result reuse
module div_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             stall,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic [4:0]       resp_rd,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sign,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);
  localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, WAIT = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [2:0]       state_q, state_d;
  logic             sel_rem_q, sel_rem_d, sign_q, sign_d;
  logic [WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, quo_q, quo_d, rem_q, rem_d;
  logic [4:0]       rd_q, rd_d;
  logic             c_valid_q, c_valid_d, c_sign_q, c_sign_d;
  logic [WIDTH-1:0] c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  logic             accept, ovf, hit;
  assign accept = req_valid && !flush && !div_busy;
  assign ovf = !req_op[0] && req_rs1 == MIN && req_rs2 == '1;
  assign hit = CACHE_EN && c_valid_q && c_rs1_q == req_rs1 && c_rs2_q == req_rs2 && c_sign_q == !req_op[0];
  always_comb begin
    state_d = state_q;
    sel_rem_d = sel_rem_q;
    sign_d = sign_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d = rd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    c_valid_d = c_valid_q;
    c_sign_d = c_sign_q;
    c_rs1_d = c_rs1_q;
    c_rs2_d = c_rs2_q;
    c_quo_d = c_quo_q;
    c_rem_d = c_rem_q;
    case (state_q)
      IDLE: if (accept) begin
        sel_rem_d = req_op[1];
        sign_d = !req_op[0];
        rs1_d = req_rs1;
        rs2_d = req_rs2;
        rd_d = req_rd;
        state_d = DONE;
        if (req_rs2 == '0) begin
          quo_d = '1;
          rem_d = req_rs1;
        end else if (ovf) begin
          quo_d = MIN;
          rem_d = '0;
        end else if (hit) begin
          quo_d = c_quo_q;
          rem_d = c_rem_q;
        end else state_d = LAUNCH;
      end
      LAUNCH: state_d = flush ? IDLE : WAIT;
      WAIT: if (flush) state_d = DRAIN;
      else if (!div_busy) begin
        quo_d = div_quotient;
        rem_d = div_remainder;
        c_valid_d = 1'b1;
        c_sign_d = sign_q;
        c_rs1_d = rs1_q;
        c_rs2_d = rs2_q;
        c_quo_d = div_quotient;
        c_rem_d = div_remainder;
        state_d = DONE;
      end
      DRAIN: state_d = div_busy ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_rem_q <= 1'b0;
      sign_q <= 1'b0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      c_valid_q <= 1'b0;
      c_sign_q <= 1'b0;
      c_rs1_q <= '0;
      c_rs2_q <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else begin
      state_q <= state_d;
      sel_rem_q <= sel_rem_d;
      sign_q <= sign_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q <= rd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      c_valid_q <= c_valid_d;
      c_sign_q <= c_sign_d;
      c_rs1_q <= c_rs1_d;
      c_rs2_q <= c_rs2_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
    end
  end
  assign div_start = state_q == LAUNCH && !flush;
  assign resp_valid = state_q == DONE && !flush;
  assign resp_data = resp_valid ? (sel_rem_q ? rem_q : quo_q) : '0;
  assign resp_rd = resp_valid ? rd_q : '0;
  assign stall = req_valid && !resp_valid;
  assign div_dividend = rs1_q;
  assign div_divisor = rs2_q;
  assign div_sign = sign_q;
endmodule
